// File: rtl/score_counter_bcd_pkg.sv
// Package flappy_score_pkg: shared types and constants for the Flappy score counter.
//   state_t     : round FSM states IDLE / RUN / OVER
//   bcd_digit_t : one BCD digit (4 bits, legal values 0..9)
//   SEG_*       : active-low 7-segment patterns {g..a} for digits 0..9 and a blank code
// No ports; imported by every file of the score counter.
package flappy_score_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/score_counter_bcd_if.sv
// Interface score_counter_bcd_if: groups the round controls and display outputs of
// the score counter.
//   inputs to the counter : start, score, fail, crush, clear (all level signals)
//   outputs of the counter: hex, bcd, rollover, saturated, game_over
//   with HIGH_SCORE_EN    : best_hex, new_best as extra counter outputs
// Modports: master drives the controls (game logic / bench), slave is the counter.
interface score_counter_bcd_if #(
    parameter int NUM_DIGITS = 3
) ();

    logic                      start;
    logic                      score;
    logic                      fail;
    logic                      crush;
    logic                      clear;
    logic [7*NUM_DIGITS-1:0]   hex;
    logic [4*NUM_DIGITS-1:0]   bcd;
    logic                      rollover;
    logic                      saturated;
    logic                      game_over;
`ifdef HIGH_SCORE_EN
    logic [7*NUM_DIGITS-1:0]   best_hex;
    logic                      new_best;
`endif

`ifdef HIGH_SCORE_EN
    modport master (
        output start, score, fail, crush, clear,
        input  hex, bcd, rollover, saturated, game_over, best_hex, new_best
    );
    modport slave (
        input  start, score, fail, crush, clear,
        output hex, bcd, rollover, saturated, game_over, best_hex, new_best
    );
`else
    modport master (
        output start, score, fail, crush, clear,
        input  hex, bcd, rollover, saturated, game_over
    );
    modport slave (
        input  start, score, fail, crush, clear,
        output hex, bcd, rollover, saturated, game_over
    );
`endif

endinterface

// File: rtl/score_counter_bcd_seg7_decode.sv
// seg7_decode: combinational BCD digit to active-low 7-segment decoder.
//   bcd : in  bcd_digit_t, value 0..9 (codes 10..15 show blank)
//   seg : out 7-bit active-low segments {g..a}
import flappy_score_pkg::*;

module seg7_decode (
    input  bcd_digit_t  bcd,
    output logic [6:0]  seg
);

    // Digit lookup; any non-decimal code blanks the display
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_counter_bcd.sv
// score_counter_bcd: NUM_DIGITS-digit BCD score counter with a round FSM
// (IDLE/RUN/OVER) and per-digit 7-segment outputs for the Flappy game.
//   Clock : system clock, all state changes on posedge
//   reset : synchronous, active-high
//   bus   : score_counter_bcd_if.slave (start/score/fail/crush/clear in;
//           hex/bcd/rollover/saturated/game_over out)
// Parameters: NUM_DIGITS (1..6), WRAP (1: wrap all-9s to 0 with rollover pulse,
//             0: saturate at all-9s).
// Optional feature macro HIGH_SCORE_EN: adds a best-score register (survives clear)
// with best_hex display and a one-cycle new_best pulse when a round beats it.
import flappy_score_pkg::*;

module score_counter_bcd #(
    parameter int NUM_DIGITS = 3,
    parameter bit WRAP       = 1'b1
) (
    input  logic               Clock,
    input  logic               reset,
    score_counter_bcd_if.slave bus
);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [4*NUM_DIGITS-1:0] count_r;
    logic [4*NUM_DIGITS-1:0] count_inc_s;
    logic [7*NUM_DIGITS-1:0] hex_s;
    logic                    all_nines_s;
    logic                    inc_s;
    logic                    rollover_r;

    // Same-cycle fail/crush wins over a score pulse
    assign inc_s = (state_r == RUN) && bus.score && !bus.fail && !bus.crush && !bus.clear;

    // Round FSM state register
    always_ff @(posedge Clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Round FSM next state; clear returns to IDLE from any state
    always_comb begin
        state_nxt_s = state_r;
        if (bus.clear) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) state_nxt_s = RUN;
                    else           state_nxt_s = IDLE;
                end
                RUN: begin
                    if (bus.fail || bus.crush) state_nxt_s = OVER;
                    else if (!bus.start)       state_nxt_s = IDLE;
                    else                       state_nxt_s = RUN;
                end
                OVER:    state_nxt_s = OVER;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // BCD ripple increment; the carry surviving past the top digit means all-9s
    always_comb begin
        logic       carry_v;
        bcd_digit_t digit_v;
        carry_v     = 1'b1;
        digit_v     = 4'd0;
        count_inc_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_v = count_r[4*i +: 4];
            if (carry_v) begin
                if (digit_v >= 4'd9) begin
                    count_inc_s[4*i +: 4] = 4'd0;
                    carry_v               = 1'b1;
                end else begin
                    count_inc_s[4*i +: 4] = digit_v + 4'd1;
                    carry_v               = 1'b0;
                end
            end else begin
                count_inc_s[4*i +: 4] = digit_v;
            end
        end
        all_nines_s = carry_v;
    end

    // Score register and rollover pulse; saturating builds hold all-9s
    always_ff @(posedge Clock) begin
        if (reset || bus.clear) begin
            count_r    <= '0;
            rollover_r <= 1'b0;
        end else if (inc_s) begin
            if (all_nines_s && !WRAP) begin
                count_r    <= count_r;
                rollover_r <= 1'b0;
            end else begin
                count_r    <= count_inc_s;
                rollover_r <= all_nines_s;
            end
        end else begin
            rollover_r <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hex
        seg7_decode u_seg (
            .bcd (count_r[4*g +: 4]),
            .seg (hex_s[7*g +: 7])
        );
    end

    assign bus.hex       = hex_s;
    assign bus.bcd       = count_r;
    assign bus.rollover  = rollover_r;
    assign bus.saturated = !WRAP && all_nines_s;
    assign bus.game_over = (state_r == OVER);

`ifdef HIGH_SCORE_EN
    logic [4*NUM_DIGITS-1:0] best_r;
    logic [7*NUM_DIGITS-1:0] best_hex_s;
    logic                    new_best_r;
    logic                    round_end_s;

    assign round_end_s = (state_r == RUN) && (state_nxt_s == OVER);

    // Best score capture at round end; packed BCD compares like binary digit-wise
    always_ff @(posedge Clock) begin
        if (reset) begin
            best_r     <= '0;
            new_best_r <= 1'b0;
        end else if (round_end_s && (count_r > best_r)) begin
            best_r     <= count_r;
            new_best_r <= 1'b1;
        end else begin
            new_best_r <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_best_hex
        seg7_decode u_seg (
            .bcd (best_r[4*g +: 4]),
            .seg (best_hex_s[7*g +: 7])
        );
    end

    assign bus.best_hex = best_hex_s;
    assign bus.new_best = new_best_r;
`endif

endmodule
